// File: rtl/la_capture_core.sv
// Logic-analyser capture core: circular sample RAM with pre-trigger window.
// Optional edge-qualified pattern trigger: define LA_TRIG_EDGE_EN.
module la_capture_core #(
  parameter int W       = 48,
  parameter int AW      = 8,
  parameter int PRETRIG = 16
) (
  input  logic          PCI_CLK,
  input  logic          PCI_RST,
  input  logic [W-1:0]  LA_DIN,
  input  logic          LA_ARM,
  input  logic          LA_ABORT,
  input  logic          LA_EXT_TRIG,
  input  logic [W-1:0]  LA_TRIG_MASK,
  input  logic [W-1:0]  LA_TRIG_VALUE,
`ifdef LA_TRIG_EDGE_EN
  input  logic [W-1:0]  LA_TRIG_EDGE_MASK,
`endif
  output logic [2:0]    LA_STATE,
  output logic          LA_DONE,
  output logic [AW-1:0] LA_TRIG_PTR,
  input  logic          LA_RD_EN,
  input  logic [AW-1:0] LA_RD_ADDR,
  output logic [W-1:0]  LA_RD_DATA,
  output logic          LA_RD_VALID
);

  localparam int DEPTH = 2 ** AW;
  localparam int POSTN = DEPTH - PRETRIG - 1;
  localparam logic [AW-1:0] PRE_LAST  = AW'(PRETRIG - 1);
  localparam logic [AW-1:0] POST_LAST = AW'(POSTN - 1);
  localparam logic [AW-1:0] PRE_OFS   = AW'(PRETRIG);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] trig_ptr_q, trig_ptr_d;
  logic          rd_valid_q, rd_valid_d;
  logic [W-1:0]  rd_data_q, rd_data_d;
  logic [W-1:0]  mem_q [DEPTH];

  logic          we;
  logic          pat_hit;
  logic          trig;
  logic          rd_fire;
  logic [AW-1:0] rd_phys;

`ifdef LA_TRIG_EDGE_EN
  logic [W-1:0]  prev_q, prev_d;
  logic          prev_vld_q, prev_vld_d;
  logic          edge_ok;

  // Previous probe sample; only meaningful after a sampling cycle.
  always_comb begin
    prev_d     = LA_DIN;
    prev_vld_d = (state_q == S_FILL) || (state_q == S_WAIT);
    edge_ok    = (LA_TRIG_EDGE_MASK == '0) ||
                 (prev_vld_q &&
                  (((LA_DIN ^ prev_q) & LA_TRIG_EDGE_MASK) != '0));
  end

  // Edge history registers.
  always_ff @(posedge PCI_CLK) begin
    if (PCI_RST) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
    end
  end
`endif

  // Trigger qualification and read-address translation.
  always_comb begin
    pat_hit = (LA_TRIG_MASK != '0) &&
              (((LA_DIN ^ LA_TRIG_VALUE) & LA_TRIG_MASK) == '0);
`ifdef LA_TRIG_EDGE_EN
    pat_hit = pat_hit && edge_ok;
`endif
    trig    = LA_EXT_TRIG || pat_hit;
    we      = (state_q == S_FILL) || (state_q == S_WAIT) ||
              (state_q == S_POST);
    rd_fire = LA_RD_EN && (state_q == S_DONE);
    rd_phys = trig_ptr_q - PRE_OFS + LA_RD_ADDR;
  end

  // Capture sequencer: next state, counters and trigger pointer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    trig_ptr_d = trig_ptr_q;
    wp_d       = we ? wp_q + 1'b1 : wp_q;
    if (LA_ABORT) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (LA_ARM) begin
            cnt_d   = '0;
            state_d = (PRETRIG == 0) ? S_WAIT : S_FILL;
          end
        end
        S_FILL: begin
          if (cnt_q == PRE_LAST) begin
            cnt_d   = '0;
            state_d = S_WAIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (trig) begin
            trig_ptr_d = wp_q;
            cnt_d      = '0;
            state_d    = (POSTN == 0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          if (cnt_q == POST_LAST) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Read port: one-cycle latency, data held when idle.
  always_comb begin
    rd_valid_d = rd_fire;
    rd_data_d  = rd_fire ? mem_q[rd_phys] : rd_data_q;
  end

  // Control and read registers.
  always_ff @(posedge PCI_CLK) begin
    if (PCI_RST) begin
      state_q    <= S_IDLE;
      wp_q       <= '0;
      cnt_q      <= '0;
      trig_ptr_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      cnt_q      <= cnt_d;
      trig_ptr_q <= trig_ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Sample RAM; contents survive abort and reset.
  always_ff @(posedge PCI_CLK) begin
    if (we) begin
      mem_q[wp_q] <= LA_DIN;
    end
  end

  assign LA_STATE    = state_q;
  assign LA_DONE     = (state_q == S_DONE);
  assign LA_TRIG_PTR = trig_ptr_q;
  assign LA_RD_DATA  = rd_data_q;
  assign LA_RD_VALID = rd_valid_q;

endmodule

// File: tb/tb_la_capture_core.sv
// Scoreboard bench for la_capture_core (W=8, AW=4, PRETRIG=4).
// Directed captures; a monitor checks every read response.
module tb_la_capture_core;

  localparam int W  = 8;
  localparam int AW = 4;
  localparam int PRE = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  din;
  logic          arm, abort_i, ext;
  logic [W-1:0]  mask, value;
`ifdef LA_TRIG_EDGE_EN
  logic [W-1:0]  edge_mask;
`endif
  logic [2:0]    st;
  logic          done;
  logic [AW-1:0] tptr;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          rd_valid;

  int checks   = 0;
  int failures = 0;
  int cnt      = 0;
  logic [W-1:0] exp_q [$];

  always #5 clk = ~clk;

  la_capture_core #(.W(W), .AW(AW), .PRETRIG(PRE)) dut (
    .PCI_CLK       (clk),
    .PCI_RST       (rst),
    .LA_DIN        (din),
    .LA_ARM        (arm),
    .LA_ABORT      (abort_i),
    .LA_EXT_TRIG   (ext),
    .LA_TRIG_MASK  (mask),
    .LA_TRIG_VALUE (value),
`ifdef LA_TRIG_EDGE_EN
    .LA_TRIG_EDGE_MASK (edge_mask),
`endif
    .LA_STATE      (st),
    .LA_DONE       (done),
    .LA_TRIG_PTR   (tptr),
    .LA_RD_EN      (rd_en),
    .LA_RD_ADDR    (rd_addr),
    .LA_RD_DATA    (rd_data),
    .LA_RD_VALID   (rd_valid)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every valid read beat must match the oldest expectation.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected actual=%0h required=none", rd_data);
      end else begin
        chk("rd_data", int'(rd_data), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // ARM with din=0, then count up until the given state is seen.
  task automatic run(input string tag, input int ext_at,
                     input logic [2:0] stop_st);
    arm = 1'b1;
    cnt = 0;
    din = 8'h00;
    step();
    arm = 1'b0;
    chk({tag, "_armed"}, int'(st), (PRE == 0) ? 2 : 1);
    for (int n = 0; n < 600; n++) begin
      cnt++;
      din = 8'(cnt);
      ext = (cnt == ext_at);
      step();
      if (st == stop_st) break;
    end
    ext = 1'b0;
    chk({tag, "_reach"}, int'(st), int'(stop_st));
  endtask

  // Queue expectations for all 16 logical indices, oldest first.
  task automatic read_all(input logic [W-1:0] trig_val);
    for (int i = 0; i < 16; i++) begin
      rd_en   = 1'b1;
      rd_addr = 4'(i);
      exp_q.push_back(8'(trig_val - 8'(PRE) + 8'(i)));
      step();
    end
    rd_en = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk("rd_drain", exp_q.size(), 0);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_state"}, int'(st), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_tptr"}, int'(tptr), 0);
    chk({tag, "_rvalid"}, int'(rd_valid), 0);
    chk({tag, "_rdata"}, int'(rd_data), 0);
  endtask

  initial begin
    rst = 1'b1; din = '0; arm = 0; abort_i = 0; ext = 0;
    mask = '0; value = '0; rd_en = 0; rd_addr = '0;
`ifdef LA_TRIG_EDGE_EN
    edge_mask = '0;
`endif
    do_reset();
    check_reset_outs("por");

    // 1: pattern 0x20; after reset sample k lands at wp k-1.
    mask = 8'hFF; value = 8'h20;
    run("s1", -1, 3'd4);
    chk("s1_done", int'(done), 1);
    chk("s1_tptr", int'(tptr), 15);
    read_all(8'h20);

    // 2a: 0x02 hit in FILL ignored, recurs at cycle 258.
    // wp starts at 11, so sample k lands at (10+k) mod 16.
    value = 8'h02;
    run("s2a", -1, 3'd4);
    chk("s2a_cnt", cnt, 258 + 11);
    chk("s2a_tptr", int'(tptr), 12);
    read_all(8'h02);

    // 2b: external trigger at sample 9; wp starts at 8.
    mask = 8'h00;
    run("s2b", 9, 3'd4);
    chk("s2b_tptr", int'(tptr), 0);
    read_all(8'h09);

    // 3: abort mid-POST, then reads are refused.
    mask = 8'hFF; value = 8'h20;
    run("s3", -1, 3'd3);
    step();
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("s3_abort_state", int'(st), 0);
    chk("s3_abort_done", int'(done), 0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("s3_rvalid0", int'(rd_valid), 0);
    step();
    chk("s3_rvalid1", int'(rd_valid), 0);
    arm = 1'b1; abort_i = 1'b1;
    step();
    arm = 1'b0; abort_i = 1'b0;
    chk("s3_arm_abort", int'(st), 0);

    // 5: reset mid-POST, then scenario 1 again.
    run("s5", -1, 3'd3);
    step();
    do_reset();
    check_reset_outs("s5_rst");
    run("s5b", -1, 3'd4);
    chk("s5_tptr", int'(tptr), 15);
    read_all(8'h20);

    // 4: trigger at 0x40 after four wp wraps from reset.
    do_reset();
    value = 8'h40;
    run("s4", -1, 3'd4);
    chk("s4_tptr", int'(tptr), 15);
    read_all(8'h40);

`ifdef LA_TRIG_EDGE_EN
    // 6: level-held bit0 must not fire; a 0->1 edge must.
    do_reset();
    mask = 8'h01; value = 8'h01; edge_mask = 8'h01;
    arm = 1'b1; din = 8'h01;
    step();
    arm = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("s6_hold", int'(st), 2);
    din = 8'h00;
    step();
    chk("s6_low", int'(st), 2);
    din = 8'h01;
    step();
    chk("s6_edge", int'(st), 3);
    mask = 8'h00; edge_mask = 8'h00;
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
